wb_writer: RTL and testbench

Writeback-side writer for the 32-entry register file. Accepts results from the ALU (single-cycle) and the load path (memory), and serialises them into at most one register-file write per cycle on `regwrite`/`writeregister`/`writedata`. Buffers ALU results in a small FIFO while loads hold the write port, and applies a fairness limit so loads cannot starve ALU results. Keeps a per-register busy scoreboard that decode uses to stall on pending writes.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 54 +++++
 rtl/wb_writer.sv | 110 +++++++++++
 tb/tb_wb_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback writer
// Purpose: register-file geometry, writer defaults and the FIFO entry type.
package wb_pkg;

    localparam int AW              = 5;
    localparam int DW              = 32;
    localparam int NREG            = 32;
    localparam int DEPTH_DEF       = 4;
    localparam int MAX_MEM_RUN_DEF = 3;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of pending ALU writeback entries
// Purpose: holds ALU results while loads own the write port.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, entry : enqueue entry (ignored when full)
//   pop         : dequeue head (ignored when empty)
//   full, empty : occupancy flags
//   head        : oldest entry, valid when !empty
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    wb_entry_t    mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= entry;
    end

endmodule

// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - register-file writeback arbiter with busy scoreboard
// Purpose: merges ALU and load results into one registered write per cycle,
// bounding consecutive load wins while ALU results wait, and tracks pending
// writes per register for decode.
// Ports:
//   clk, rst_n                           : clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data  : ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data  : load result handshake
//   issue_valid, issue_rd                : decode issue marking rd pending
//   busy                                 : per-register pending-write bits
//   regwrite, writeregister, writedata   : registered register-file write port
module wb_writer
    import wb_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int MAX_MEM_RUN = MAX_MEM_RUN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic [NREG-1:0] busy,
    output logic            regwrite,
    output logic [AW-1:0]   writeregister,
    output logic [DW-1:0]   writedata
);

    localparam int RW = $clog2(MAX_MEM_RUN + 1);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_MEM_RUN);

    logic            fifo_full;
    logic            fifo_empty;
    wb_entry_t       fifo_head;
    wb_entry_t       alu_entry;
    logic            alu_push;
    logic            mem_win;
    logic            pop;
    logic [RW-1:0]   run_cnt;
    logic [NREG-1:0] busy_next;

    // Writes to r0 are architecturally void, so they never occupy a FIFO slot.
    assign alu_ready  = !fifo_full;
    assign alu_push   = alu_valid && alu_ready && (alu_rd != '0);
    assign alu_entry  = '{rd: alu_rd, data: alu_data};

    assign mem_ready  = fifo_empty || (run_cnt < RUN_LIMIT);
    assign mem_win    = mem_valid && mem_ready;
    assign pop        = !mem_win && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (alu_push),
        .entry (alu_entry),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Run length counts only load wins that actually made ALU entries wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (fifo_empty || pop) begin
            run_cnt <= '0;
        end else if (mem_win) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite      <= 1'b0;
            writeregister <= '0;
            writedata     <= '0;
        end else if (mem_win) begin
            regwrite      <= (mem_rd != '0);
            writeregister <= mem_rd;
            writedata     <= mem_data;
        end else if (pop) begin
            regwrite      <= 1'b1;
            writeregister <= fifo_head.rd;
            writedata     <= fifo_head.data;
        end else begin
            regwrite      <= 1'b0;
        end
    end

    // Clear applied first so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (regwrite) busy_next[writeregister] = 1'b0;
        if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - directed self-checking bench for wb_writer
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        regwrite;
    logic [4:0]  writeregister;
    logic [31:0] writedata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .busy          (busy),
        .regwrite      (regwrite),
        .writeregister (writeregister),
        .writedata     (writedata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_regwrite"}, {31'd0, regwrite}, 32'd1);
        chk({tag, "_wreg"}, {27'd0, writeregister}, {27'd0, rd});
        chk({tag, "_wdata"}, writedata, data);
    endtask

    // Decode must never issue to a pending register unless it retires this cycle.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_rd != 5'd0) begin
            assert (!busy[issue_rd] || (regwrite && writeregister == issue_rd)) else begin
                fails++;
                $error("FAIL issue_to_busy observed=busy[%0d]=1 expected=0", issue_rd);
            end
        end
    end

    initial begin
        bit          exp_a;
        int          mem_idx;

        rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        tick; tick;
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_wreg", {27'd0, writeregister}, 32'd0);
        chk("rst_wdata", writedata, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        rst_n = 1'b1;
        tick;

        // Single ALU result: write two cycles after acceptance, busy clears one later.
        issue_valid = 1'b1; issue_rd = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick;
        issue_valid = 1'b0; alu_valid = 1'b0;
        chk("single_busy_set", busy, 32'h0000_0020);
        chk("single_no_early_write", {31'd0, regwrite}, 32'd0);
        tick;
        chk_wr("single", 5'd5, 32'h1234);
        chk("single_busy_held", busy, 32'h0000_0020);
        tick;
        chk("single_busy_clear", busy, 32'd0);
        chk("single_write_done", {31'd0, regwrite}, 32'd0);

        // rd = 0 from both sources: accepted, never written.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hdead;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hbeef;
        chk("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("r0_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick;
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("r0_no_write_a", {31'd0, regwrite}, 32'd0);
        tick;
        chk("r0_no_write_b", {31'd0, regwrite}, 32'd0);
        chk("r0_busy", busy, 32'd0);

        // Build FIFO = {A2, A3} with run count zero.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h200;
        tick;
        chk_wr("pre_m20", 5'd20, 32'h200);
        alu_rd = 5'd2; alu_data = 32'hA2; mem_rd = 5'd21; mem_data = 32'h201;
        tick;
        chk_wr("pre_m21", 5'd21, 32'h201);
        alu_rd = 5'd3; alu_data = 32'hA3; mem_valid = 1'b0;
        tick;
        chk_wr("pre_a1", 5'd1, 32'hA1);

        // Fairness window: M,M,M,A,M,M,M,A.
        alu_valid = 1'b0;
        mem_idx = 0;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h100;
        for (int i = 0; i < 8; i++) begin
            exp_a = (i == 3) || (i == 7);
            chk("fair_mem_ready", {31'd0, mem_ready}, exp_a ? 32'd0 : 32'd1);
            tick;
            if (exp_a) begin
                chk_wr("fair_alu", (i == 3) ? 5'd2 : 5'd3, (i == 3) ? 32'hA2 : 32'hA3);
            end else begin
                chk_wr("fair_mem", 5'(10 + mem_idx), 32'h100 + 32'(mem_idx));
                mem_idx++;
                mem_rd = 5'(10 + mem_idx);
                mem_data = 32'h100 + 32'(mem_idx);
            end
        end
        mem_valid = 1'b0;
        tick;
        chk("fair_idle", {31'd0, regwrite}, 32'd0);

        // FIFO full: four entries under a load stream, fifth stalls.
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(24 + k); alu_data = 32'hB1 + 32'(k);
            mem_valid = 1'b1; mem_rd = 5'(16 + k); mem_data = 32'h180 + 32'(k);
            chk("full_alu_ready", {31'd0, alu_ready}, 32'd1);
            tick;
            chk_wr("full_load", 5'(16 + k), 32'h180 + 32'(k));
        end
        alu_rd = 5'd28; alu_data = 32'hB5; mem_valid = 1'b0;
        chk("full_alu_stall", {31'd0, alu_ready}, 32'd0);
        chk("full_mem_block", {31'd0, mem_ready}, 32'd0);
        tick;
        chk_wr("drain_b1", 5'd24, 32'hB1);
        chk("full_alu_reopen", {31'd0, alu_ready}, 32'd1);
        tick;
        alu_valid = 1'b0;
        chk_wr("drain_b2", 5'd25, 32'hB2);
        tick;
        chk_wr("drain_b3", 5'd26, 32'hB3);
        tick;
        chk_wr("drain_b4", 5'd27, 32'hB4);
        tick;
        chk_wr("drain_b5", 5'd28, 32'hB5);
        tick;
        chk("drain_idle", {31'd0, regwrite}, 32'd0);

        // Scoreboard collision: set wins over same-cycle clear.
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick;
        issue_valid = 1'b0; alu_valid = 1'b0;
        chk("coll_busy_set", busy, 32'h0000_0200);
        tick;
        chk_wr("coll_write", 5'd9, 32'h99);
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick;
        issue_valid = 1'b0;
        chk("coll_busy_kept", busy, 32'h0000_0200);

        // Reset mid-stream with three queued entries and busy = 0x220.
        issue_valid = 1'b1; issue_rd = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hC1;
        mem_valid = 1'b1; mem_rd = 5'd30; mem_data = 32'h300;
        tick;
        issue_valid = 1'b0; alu_rd = 5'd9; alu_data = 32'hC2;
        tick;
        alu_rd = 5'd7; alu_data = 32'hC3;
        tick;
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("prerst_busy", busy, 32'h0000_0220);
        chk_wr("prerst_load", 5'd30, 32'h300);
        rst_n = 1'b0;
        #1;
        chk("midrst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_wreg", {27'd0, writeregister}, 32'd0);
        chk("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick;
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick;
            chk("postrst_no_write", {31'd0, regwrite}, 32'd0);
            chk("postrst_busy", busy, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
